alu_ctrl_seq: RTL and testbench

- Registered, parametrised ALU control unit for the pipelined/multi-cycle processor; sits between ID and EX.
- Decodes alu_op/func into a widened ALU control code with one-cycle latency.
- Adds the full R-type set (xor, nor, srl, sra, sltu, subu) plus mult/multu/div/divu sequencing.
- Holds off new instructions with an in_ready handshake while a multiply/divide is in flight, and pulses the HI/LO write at completion.

---
 rtl/alu_ctrl_seq.sv | 149 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decode between ID and EX, with mult/div sequencing.
// Holds off new requests while a multiply/divide is in flight and strobes HI/LO at completion.
module alu_ctrl_seq #(
  parameter int CTR_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       func,
  input  logic             flush,
  output logic             out_valid,
  output logic [CTR_W-1:0] alu_ctr,
  output logic             r_we,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_busy,
  output logic             hilo_we,
  output logic             mf_en,
  output logic             mf_sel,
  output logic             illegal
);
  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010,
                         C_XOR = 4'b0011, C_NOR = 4'b0100, C_SLL = 4'b0101,
                         C_SUB = 4'b0110, C_SLT = 4'b0111, C_SRL = 4'b1000,
                         C_SRA = 4'b1001, C_SLTU = 4'b1010;

  // Counter preload is LAT-1: the cycle with cnt==0 is the last busy cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  logic [3:0] d_ctr;
  logic       d_rwe, d_ill, d_mf, d_mfsel, d_md;
  logic [1:0] d_mdop;

  assign in_ready = (state == IDLE);
  assign md_busy  = (state == MD_WAIT);
  assign hilo_we  = (state == MD_WAIT) && (cnt == '0);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    d_ctr   = C_ADD;
    d_rwe   = 1'b0;
    d_ill   = 1'b0;
    d_mf    = 1'b0;
    d_mfsel = mf_sel;
    d_md    = 1'b0;
    d_mdop  = md_op;
    if (!alu_op[2]) begin
      unique case (alu_op[1:0])
        2'b00: d_ctr = C_ADD;
        2'b01: d_ctr = C_SUB;
        2'b10: d_ctr = C_OR;
        2'b11: d_ctr = C_SLT;
      endcase
    end else begin
      d_rwe = 1'b1;
      case (func)
        6'b000000:            d_ctr = C_SLL;
        6'b000010:            d_ctr = C_SRL;
        6'b000011:            d_ctr = C_SRA;
        6'b100000, 6'b100001: d_ctr = C_ADD;
        6'b100010, 6'b100011: d_ctr = C_SUB;
        6'b100100:            d_ctr = C_AND;
        6'b100101:            d_ctr = C_OR;
        6'b100110:            d_ctr = C_XOR;
        6'b100111:            d_ctr = C_NOR;
        6'b101010:            d_ctr = C_SLT;
        6'b101011:            d_ctr = C_SLTU;
        6'b010000, 6'b010010: begin
          d_mf    = 1'b1;
          d_mfsel = ~func[1];
        end
        6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
          d_rwe  = 1'b0;
          d_md   = 1'b1;
          d_mdop = func[1:0];
        end
        default: begin
          d_rwe = 1'b0;
          d_ill = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: if (accept && d_md) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = d_mdop[1] ? DIV_LOAD : MUL_LOAD;
        end
        MD_WAIT: if (cnt != '0) cnt_nxt = cnt - 1'b1;
                 else           state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Strobes live for one cycle; code fields hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r_we      <= 1'b0;
      mf_en     <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      alu_ctr   <= CTR_W'(C_ADD);
      md_op     <= 2'b00;
      mf_sel    <= 1'b0;
    end else begin
      out_valid <= accept;
      r_we      <= accept & d_rwe;
      mf_en     <= accept & d_mf;
      illegal   <= accept & d_ill;
      md_start  <= accept & d_md;
      if (accept) begin
        alu_ctr <= CTR_W'(d_ctr);
        md_op   <= d_mdop;
        mf_sel  <= d_mfsel;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: scoreboard of expected decodes plus a busy-cycle model.
module tb_alu_ctrl_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 0, flush = 0, in_valid1 = 0, flush1 = 0;
  logic [2:0] alu_op = 0;
  logic [5:0] func = 0;
  logic       in_ready, out_valid, r_we, md_start, md_busy, hilo_we, mf_en, mf_sel, illegal;
  logic [3:0] alu_ctr;
  logic [1:0] md_op;
  logic       in_ready1, out_valid1, r_we1, md_start1, md_busy1, hilo_we1, mf_en1, mf_sel1, illegal1;
  logic [3:0] alu_ctr1;
  logic [1:0] md_op1;

  alu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func(func), .flush(flush), .out_valid(out_valid),
    .alu_ctr(alu_ctr), .r_we(r_we), .md_start(md_start), .md_op(md_op),
    .md_busy(md_busy), .hilo_we(hilo_we), .mf_en(mf_en), .mf_sel(mf_sel),
    .illegal(illegal));

  alu_ctrl_seq #(.MUL_LAT(1), .DIV_LAT(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_op(alu_op), .func(func), .flush(flush1), .out_valid(out_valid1),
    .alu_ctr(alu_ctr1), .r_we(r_we1), .md_start(md_start1), .md_op(md_op1),
    .md_busy(md_busy1), .hilo_we(hilo_we1), .mf_en(mf_en1), .mf_sel(mf_sel1),
    .illegal(illegal1));

  typedef struct {
    logic [3:0] ctr;
    logic rwe, ill, mf, mfsel, md;
    logic [1:0] mdop;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [5:0] f;
    logic [3:0] ctr;
    logic rwe, ill;
  } vec_t;

  exp_t       sbq[$];
  int         vecs = 0, miss = 0;
  int         busy = 0;
  logic [3:0] last_ctr = 4'h2;
  vec_t       tbl[19];

  function automatic exp_t mk(logic [3:0] ctr, logic rwe, logic ill, logic mf,
                              logic mfsel, logic md, logic [1:0] mdop);
    exp_t e;
    e.ctr = ctr; e.rwe = rwe; e.ill = ill; e.mf = mf;
    e.mfsel = mfsel; e.md = md; e.mdop = mdop;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, predict accept, cross the edge, compare.
  task automatic step(input logic v, input logic [2:0] op, input logic [5:0] f,
                      input logic fl, input exp_t e);
    bit   acc;
    exp_t x;
    in_valid = v; alu_op = op; func = f; flush = fl;
    acc = v && (busy == 0) && !fl;
    if (acc) sbq.push_back(e);
    @(posedge clk); #1;
    if (fl)                busy = 0;
    else if (busy > 0)     busy--;
    else if (acc && e.md)  busy = e.mdop[1] ? 32 : 4;
    chk("out_valid", out_valid, acc);
    chk("md_start", md_start, acc && e.md);
    if (out_valid === 1'b1) begin
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        last_ctr = x.ctr;
        chk("r_we", r_we, x.rwe);
        chk("illegal", illegal, x.ill);
        chk("mf_en", mf_en, x.mf);
        if (x.mf) chk("mf_sel", mf_sel, x.mfsel);
        if (x.md) chk("md_op", md_op, x.mdop);
      end else chk("sb_underflow", sbq.size(), 1);
    end else begin
      chk("r_we_idle", r_we, 0);
      chk("illegal_idle", illegal, 0);
      chk("mf_en_idle", mf_en, 0);
    end
    chk("alu_ctr", alu_ctr, last_ctr);
    chk("in_ready", in_ready, busy == 0);
    chk("md_busy", md_busy, busy > 0);
    chk("hilo_we", hilo_we, busy == 1);
    in_valid = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 3'b000, 6'b000000, 0, mk(4'h2, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    tbl = '{
      '{3'b100, 6'b000000, 4'h5, 1'b1, 1'b0}, '{3'b100, 6'b000010, 4'h8, 1'b1, 1'b0},
      '{3'b100, 6'b000011, 4'h9, 1'b1, 1'b0}, '{3'b100, 6'b100000, 4'h2, 1'b1, 1'b0},
      '{3'b100, 6'b100001, 4'h2, 1'b1, 1'b0}, '{3'b100, 6'b100010, 4'h6, 1'b1, 1'b0},
      '{3'b100, 6'b100011, 4'h6, 1'b1, 1'b0}, '{3'b100, 6'b100100, 4'h0, 1'b1, 1'b0},
      '{3'b100, 6'b100101, 4'h1, 1'b1, 1'b0}, '{3'b100, 6'b100110, 4'h3, 1'b1, 1'b0},
      '{3'b100, 6'b100111, 4'h4, 1'b1, 1'b0}, '{3'b100, 6'b101010, 4'h7, 1'b1, 1'b0},
      '{3'b100, 6'b101011, 4'hA, 1'b1, 1'b0}, '{3'b000, 6'b100100, 4'h2, 1'b0, 1'b0},
      '{3'b001, 6'b100100, 4'h6, 1'b0, 1'b0}, '{3'b010, 6'b000000, 4'h1, 1'b0, 1'b0},
      '{3'b011, 6'b100010, 4'h7, 1'b0, 1'b0}, '{3'b100, 6'b111111, 4'h2, 1'b0, 1'b1},
      '{3'b111, 6'b100110, 4'h3, 1'b1, 1'b0}};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_ctr", alu_ctr, 4'h2);
    chk("rst_md_op", md_op, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_hilo_we", hilo_we, 0);
    chk("rst_r_we", r_we, 0);
    chk("rst_mf", {mf_en, mf_sel, illegal, md_start}, 0);
    chk("rst_in_ready1", in_ready1, 1);
    rst_n = 1;

    // sub then hold
    step(1, 3'b100, 6'b100010, 0, mk(4'h6, 1, 0, 0, 0, 0, 0));
    idle(2);

    // decode sweep, back to back
    foreach (tbl[i])
      step(1, tbl[i].op, tbl[i].f, 0, mk(tbl[i].ctr, tbl[i].rwe, tbl[i].ill, 0, 0, 0, 0));
    idle(1);
    step(1, 3'b100, 6'b010000, 0, mk(4'h2, 1, 0, 1, 1, 0, 0));
    step(1, 3'b100, 6'b010010, 0, mk(4'h2, 1, 0, 1, 0, 0, 0));

    // mult with request held: accept edge 0, re-accept edge 5
    repeat (6) step(1, 3'b100, 6'b011000, 0, mk(4'h2, 0, 0, 0, 0, 1, 2'b00));
    idle(5);

    // divu runs to completion
    step(1, 3'b100, 6'b011011, 0, mk(4'h2, 0, 0, 0, 0, 1, 2'b11));
    idle(33);

    // div flushed in busy cycle 10
    step(1, 3'b100, 6'b011010, 0, mk(4'h2, 0, 0, 0, 0, 1, 2'b10));
    idle(9);
    step(0, 3'b000, 6'b000000, 1, mk(4'h2, 0, 0, 0, 0, 0, 0));
    idle(3);

    // flush together with a valid request: no accept
    step(1, 3'b100, 6'b100100, 1, mk(4'h0, 1, 0, 0, 0, 0, 0));

    // async reset mid-divide
    step(1, 3'b100, 6'b011011, 0, mk(4'h2, 0, 0, 0, 0, 1, 2'b11));
    step(1, 3'b100, 6'b100101, 0, mk(4'h1, 1, 0, 0, 0, 0, 0));
    idle(4);
    #3 rst_n = 0;
    #1;
    chk("arst_md_busy", md_busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_hilo_we", hilo_we, 0);
    chk("arst_md_op", md_op, 0);
    chk("arst_alu_ctr", alu_ctr, 4'h2);
    busy = 0; last_ctr = 4'h2; sbq.delete();
    @(posedge clk);
    #3 rst_n = 1;
    step(1, 3'b100, 6'b010010, 0, mk(4'h2, 1, 0, 1, 0, 0, 0));
    idle(2);

    // single-cycle multiply build
    alu_op = 3'b100; func = 6'b011001; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0;
    chk("l1_out_valid", out_valid1, 1);
    chk("l1_md_start", md_start1, 1);
    chk("l1_hilo_we", hilo_we1, 1);
    chk("l1_md_busy", md_busy1, 1);
    chk("l1_in_ready", in_ready1, 0);
    chk("l1_md_op", md_op1, 2'b01);
    @(posedge clk); #1;
    chk("l1_md_busy_end", md_busy1, 0);
    chk("l1_hilo_end", hilo_we1, 0);
    chk("l1_ready_end", in_ready1, 1);
    func = 6'b100000; in_valid1 = 1; flush1 = 1;
    @(posedge clk); #1;
    chk("l1_flush_out_valid", out_valid1, 0);
    chk("l1_flush_md_start", md_start1, 0);
    flush1 = 0;
    @(posedge clk); #1;
    in_valid1 = 0;
    chk("l1_add_out_valid", out_valid1, 1);
    chk("l1_add_ctr", alu_ctr1, 4'h2);
    chk("l1_add_r_we", r_we1, 1);

    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
